dma_io_endpoint: RTL and testbench

//  Peripheral-side endpoint of the 8237A DMA channel handshake (DREQ/DACK/IOR/IOW/EOP).

---
 rtl/dma_io_if.sv | 31 +++
 rtl/dma_io_endpoint.sv | 164 ++++++++++++++++
 tb/tb_dma_io_endpoint.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_io_if.sv
// DMA channel handshake bundle between an 8237A-style controller and a peripheral.
//   dreq   : request, endpoint -> controller
//   dack   : acknowledge, controller -> endpoint
//   ior_n  : I/O read strobe (device -> memory), active-low
//   iow_n  : I/O write strobe (memory -> device), active-low
//   eop_n  : end of process / terminal count, active-low
//   db_in  : bus data presented by the controller on write cycles
//   db_out : bus data presented by the endpoint on read cycles
//   db_oe  : endpoint output enable for db_out
interface dma_io_if #(
  parameter int unsigned DATA_W = 8
);
  logic              dreq;
  logic              dack;
  logic              ior_n;
  logic              iow_n;
  logic              eop_n;
  logic [DATA_W-1:0] db_in;
  logic [DATA_W-1:0] db_out;
  logic              db_oe;

  modport master (
    input  dreq, db_out, db_oe,
    output dack, ior_n, iow_n, eop_n, db_in
  );

  modport slave (
    output dreq, db_out, db_oe,
    input  dack, ior_n, iow_n, eop_n, db_in
  );
endinterface

// File: rtl/dma_io_endpoint.sv
// Peripheral-side endpoint of an 8237A DMA channel. Buffers local data in a TX
// and an RX FIFO, raises dreq while a byte can move in the armed direction,
// answers dack + I/O strobes and stops on eop_n.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : DMA handshake bundle (slave side)
//   dir        : 0 device->memory (TX), 1 memory->device (RX); latched on start
//   start      : one-cycle pulse arming a block transfer (only from IDLE)
//   tx_push    : local TX write of tx_data (ignored when full)
//   rx_pop     : local RX read (ignored when empty); rx_data is the RX head
//   tx_full, rx_empty : FIFO status
//   done       : sticky, set on terminal count; cleared by start
//   err        : sticky, bus-side under/overflow; cleared by start
module dma_io_endpoint #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dma_io_if.slave           bus,
  input  logic              dir,
  input  logic              start,
  input  logic              tx_push,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_pop,
  output logic [DATA_W-1:0] rx_data,
  output logic              tx_full,
  output logic              rx_empty,
  output logic              done,
  output logic              err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, TERM} state_t;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic              ior_q, iow_q;
  logic [DATA_W-1:0] db_q;
  logic              dreq_d, done_d, err_d;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CW-1:0]     tx_cnt, rx_cnt;

  // Strobe trailing edges, only while the channel is granted and dir matches.
  // A strobe whose partner was also low in the previous cycle is dropped.
  logic xfer_ok, rd_edge, wr_edge;
  assign xfer_ok = ((state_q == ACTIVE) || (state_q == TERM)) && bus.dack;
  assign rd_edge = xfer_ok && !dir_q && !ior_q && bus.ior_n && iow_q;
  assign wr_edge = xfer_ok &&  dir_q && !iow_q && bus.iow_n && ior_q;

  // TX FIFO: local push, bus pop
  logic          tx_pop, tx_wr_en;
  logic [AW-1:0] tx_rd_d, tx_wr_d;
  logic [CW-1:0] tx_cnt_d;
  logic [DATA_W-1:0] tx_head_d;
  assign tx_pop    = rd_edge && (tx_cnt != '0);
  assign tx_wr_en  = tx_push && ((tx_cnt != FULL_CNT) || tx_pop);
  assign tx_rd_d   = tx_rd + AW'(tx_pop);
  assign tx_wr_d   = tx_wr + AW'(tx_wr_en);
  assign tx_cnt_d  = tx_cnt + CW'(tx_wr_en) - CW'(tx_pop);
  // Next head: bypass the word being written when it lands at the new head slot.
  assign tx_head_d = (tx_cnt_d == '0) ? '0 :
                     (tx_wr_en && (tx_rd_d == tx_wr)) ? tx_data : tx_mem[tx_rd_d];

  // RX FIFO: bus push (from the value held while iow_n was low), local pop
  logic          rx_pop_en, rx_push;
  logic [AW-1:0] rx_rd_d, rx_wr_d;
  logic [CW-1:0] rx_cnt_d;
  logic [DATA_W-1:0] rx_head_d;
  assign rx_pop_en = rx_pop && (rx_cnt != '0);
  assign rx_push   = wr_edge && ((rx_cnt != FULL_CNT) || rx_pop_en);
  assign rx_rd_d   = rx_rd + AW'(rx_pop_en);
  assign rx_wr_d   = rx_wr + AW'(rx_push);
  assign rx_cnt_d  = rx_cnt + CW'(rx_push) - CW'(rx_pop_en);
  assign rx_head_d = (rx_cnt_d == '0) ? '0 :
                     (rx_push && (rx_rd_d == rx_wr)) ? db_q : rx_mem[rx_rd_d];

  logic underflow, overflow;
  assign underflow = rd_edge && (tx_cnt == '0);
  assign overflow  = wr_edge && !rx_push;

  // Read data drive is combinational so it follows the strobe directly.
  assign bus.db_oe = xfer_ok && !dir_q && !bus.ior_n;

  // Next state and registered control outputs
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    done_d  = done;
    err_d   = err;
    unique case (state_q)
      IDLE:   if (start) begin
                state_d = ARMED;
                dir_d   = dir;
              end
      ARMED:  if (bus.dack) state_d = ACTIVE;
      ACTIVE: if (!bus.dack) state_d = ARMED;
              else if (!bus.eop_n) state_d = TERM;
      // Hold while a strobe is still low so its trailing edge can transfer.
      TERM:   if (!(bus.dack && (!bus.ior_n || !bus.iow_n))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE) && start) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (state_d == TERM) done_d = 1'b1;
    if (underflow || overflow) err_d = 1'b1;
    dreq_d = ((state_d == ARMED) || (state_d == ACTIVE)) &&
             (dir_d ? (rx_cnt_d != FULL_CNT) : (tx_cnt_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      db_q       <= '0;
      tx_rd      <= '0;
      tx_wr      <= '0;
      tx_cnt     <= '0;
      rx_rd      <= '0;
      rx_wr      <= '0;
      rx_cnt     <= '0;
      bus.dreq   <= 1'b0;
      bus.db_out <= '0;
      rx_data    <= '0;
      tx_full    <= 1'b0;
      rx_empty   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      ior_q      <= bus.ior_n;
      iow_q      <= bus.iow_n;
      if (!bus.iow_n) db_q <= bus.db_in;
      tx_rd      <= tx_rd_d;
      tx_wr      <= tx_wr_d;
      tx_cnt     <= tx_cnt_d;
      rx_rd      <= rx_rd_d;
      rx_wr      <= rx_wr_d;
      rx_cnt     <= rx_cnt_d;
      bus.dreq   <= dreq_d;
      bus.db_out <= tx_head_d;
      rx_data    <= rx_head_d;
      tx_full    <= (tx_cnt_d == FULL_CNT);
      rx_empty   <= (rx_cnt_d == '0);
      done       <= done_d;
      err        <= err_d;
    end
  end

  // FIFO storage, contents are don't-care once pointers are reset
  always_ff @(posedge clk) begin
    if (tx_wr_en) tx_mem[tx_wr] <= tx_data;
    if (rx_push)  rx_mem[rx_wr] <= db_q;
  end
endmodule

// File: tb/tb_dma_io_endpoint.sv
module tb_dma_io_endpoint;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dir, start, tx_push, rx_pop;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic              tx_full, rx_empty, done, err;

  int total = 0;
  int bad   = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  dma_io_if #(.DATA_W(DATA_W)) bus ();

  dma_io_endpoint #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dir(dir), .start(start),
    .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop), .rx_data(rx_data),
    .tx_full(tx_full), .rx_empty(rx_empty), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.dack = 1'b0; bus.ior_n = 1'b1; bus.iow_n = 1'b1; bus.eop_n = 1'b1;
    bus.db_in = '0; dir = 1'b0; start = 1'b0; tx_push = 1'b0; tx_data = '0;
    rx_pop = 1'b0;
    rst_n = 1'b0;
    cyc; cyc;
    rst_n = 1'b1;
    cyc;
    txq.delete();
    rxq.delete();
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_push = 1'b1; tx_data = d;
    cyc;
    tx_push = 1'b0;
  endtask

  task automatic pop_rx;
    rx_pop = 1'b1;
    cyc;
    rx_pop = 1'b0;
  endtask

  task automatic arm(input logic d);
    dir = d; start = 1'b1;
    cyc;
    start = 1'b0; bus.dack = 1'b1;
    cyc;
  endtask

  task automatic bus_read(output logic [7:0] obs, output logic oe);
    bus.ior_n = 1'b0;
    cyc;
    obs = bus.db_out; oe = bus.db_oe;
    bus.ior_n = 1'b1;
    cyc;
  endtask

  task automatic bus_write(input logic [7:0] d);
    bus.db_in = d; bus.iow_n = 1'b0;
    cyc;
    bus.db_in = 8'hEE; bus.iow_n = 1'b1;
    cyc;
  endtask

  task automatic finish_eop;
    bus.eop_n = 1'b0;
    cyc;
    bus.eop_n = 1'b1;
    cyc;
    bus.dack = 1'b0;
    cyc;
  endtask

  task automatic test_reset;
    logic [7:0] b0;
    do_reset;
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL rst_dreq got=%0b exp=0", bus.dreq); end
    total++; if (bus.db_out !== 8'h00) begin bad++; $display("FAIL rst_db_out got=%0h exp=0", bus.db_out); end
    total++; if ({done, err, rx_empty, tx_full} !== 4'b0010) begin bad++; $display("FAIL rst_flags got=%b exp=0010", {done, err, rx_empty, tx_full}); end
    b0 = 8'($urandom);
    push_tx(b0);
    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    arm(1'b0);
    total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL rst_pre_dreq got=%0b exp=1", bus.dreq); end
    total++; if (bus.db_out !== b0) begin bad++; $display("FAIL rst_pre_head got=%0h exp=%0h", bus.db_out, b0); end
    bus.ior_n = 1'b0;
    cyc;
    total++; if (bus.db_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_oe got=%0b exp=1", bus.db_oe); end
    rst_n = 1'b0;
    cyc;
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL rst_mid_dreq got=%0b exp=0", bus.dreq); end
    total++; if (bus.db_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_oe got=%0b exp=0", bus.db_oe); end
    total++; if (bus.db_out !== 8'h00) begin bad++; $display("FAIL rst_mid_tx_empty got=%0h exp=0", bus.db_out); end
    bus.ior_n = 1'b1; bus.dack = 1'b0;
    rst_n = 1'b1;
    cyc;
    // Re-arming from IDLE with an empty TX keeps dreq low
    arm(1'b0);
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL rst_rearm_dreq got=%0b exp=0", bus.dreq); end
    finish_eop;
  endtask

  task automatic test_read_seq;
    logic [7:0] exp [3];
    logic [7:0] obs;
    logic oe;
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    do_reset;
    for (int i = 0; i < 3; i++) push_tx(exp[i]);
    arm(1'b0);
    total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL rd_dreq_armed got=%0b exp=1", bus.dreq); end
    for (int i = 0; i < 3; i++) begin
      bus_read(obs, oe);
      total++; if (obs !== exp[i]) begin bad++; $display("FAIL rd_data%0d got=%0h exp=%0h", i, obs, exp[i]); end
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL rd_oe%0d got=%0b exp=1", i, oe); end
      total++; if (bus.dreq !== (i < 2)) begin bad++; $display("FAIL rd_dreq%0d got=%0b exp=%0b", i, bus.dreq, (i < 2)); end
    end
    finish_eop;
    total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL rd_done_err got=%b exp=10", {done, err}); end
  endtask

  task automatic test_rx_overflow;
    do_reset;
    arm(1'b1);
    total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL ovf_dreq_armed got=%0b exp=1", bus.dreq); end
    for (int i = 0; i < 17; i++) begin
      bus_write(8'(i));
      if (i == 15) begin
        total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL ovf_dreq_full got=%0b exp=0", bus.dreq); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_err_early got=%0b exp=0", err); end
      end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%0b exp=1", err); end
    finish_eop;
    for (int i = 0; i < 16; i++) begin
      total++; if (rx_data !== 8'(i) || rx_empty !== 1'b0) begin bad++; $display("FAIL ovf_drain%0d got=%0h/%0b exp=%0h/0", i, rx_data, rx_empty, 8'(i)); end
      pop_rx;
    end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%0b exp=1", rx_empty); end
  endtask

  task automatic test_eop;
    logic [7:0] b [4];
    logic [7:0] obs;
    logic oe;
    do_reset;
    for (int i = 0; i < 4; i++) begin b[i] = 8'($urandom); push_tx(b[i]); end
    arm(1'b0);
    bus_read(obs, oe);
    total++; if (obs !== b[0]) begin bad++; $display("FAIL eop_rd0 got=%0h exp=%0h", obs, b[0]); end
    bus.ior_n = 1'b0; bus.eop_n = 1'b0;
    cyc;
    obs = bus.db_out;
    bus.eop_n = 1'b1;
    cyc;
    bus.ior_n = 1'b1;
    cyc;
    total++; if (obs !== b[1]) begin bad++; $display("FAIL eop_rd1 got=%0h exp=%0h", obs, b[1]); end
    total++; if ({done, bus.dreq} !== 2'b10) begin bad++; $display("FAIL eop_done_dreq got=%b exp=10", {done, bus.dreq}); end
    total++; if (bus.db_out !== b[2]) begin bad++; $display("FAIL eop_head got=%0h exp=%0h", bus.db_out, b[2]); end
    // Strobes after termination are not transfers
    bus_read(obs, oe);
    total++; if ({oe, err} !== 2'b00 || bus.db_out !== b[2]) begin bad++; $display("FAIL eop_post got=%b/%0h exp=00/%0h", {oe, err}, bus.db_out, b[2]); end
    bus.dack = 1'b0;
    cyc;
    arm(1'b0);
    total++; if ({done, bus.dreq} !== 2'b01) begin bad++; $display("FAIL eop_restart got=%b exp=01", {done, bus.dreq}); end
    for (int i = 2; i < 4; i++) begin
      bus_read(obs, oe);
      total++; if (obs !== b[i]) begin bad++; $display("FAIL eop_rest%0d got=%0h exp=%0h", i, obs, b[i]); end
    end
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL eop_rest_dreq got=%0b exp=0", bus.dreq); end
    finish_eop;
  endtask

  task automatic test_full_pop_same_cycle;
    do_reset;
    arm(1'b1);
    for (int i = 0; i < 16; i++) bus_write(8'(i));
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL fps_dreq_full got=%0b exp=0", bus.dreq); end
    bus.db_in = 8'h5A; bus.iow_n = 1'b0;
    cyc;
    bus.iow_n = 1'b1; rx_pop = 1'b1;
    cyc;
    rx_pop = 1'b0;
    total++; if ({err, bus.dreq} !== 2'b00) begin bad++; $display("FAIL fps_err_dreq got=%b exp=00", {err, bus.dreq}); end
    finish_eop;
    for (int i = 1; i < 17; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h5A : 8'(i);
      total++; if (rx_data !== e || rx_empty !== 1'b0) begin bad++; $display("FAIL fps_drain%0d got=%0h/%0b exp=%0h/0", i, rx_data, rx_empty, e); end
      pop_rx;
    end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL fps_empty got=%0b exp=1", rx_empty); end
  endtask

  task automatic test_underflow;
    logic [7:0] obs;
    logic oe;
    do_reset;
    arm(1'b0);
    total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL unf_dreq got=%0b exp=0", bus.dreq); end
    bus_read(obs, oe);
    total++; if (obs !== 8'h00 || bus.db_out !== 8'h00) begin bad++; $display("FAIL unf_data got=%0h/%0h exp=0/0", obs, bus.db_out); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL unf_err got=%0b exp=1", err); end
    finish_eop;
    push_tx(8'h77);
    total++; if (bus.db_out !== 8'h77) begin bad++; $display("FAIL unf_ptr got=%0h exp=77", bus.db_out); end
    arm(1'b0);
    total++; if ({err, bus.dreq} !== 2'b01) begin bad++; $display("FAIL unf_restart got=%b exp=01", {err, bus.dreq}); end
    bus_read(obs, oe);
    total++; if (obs !== 8'h77) begin bad++; $display("FAIL unf_read got=%0h exp=77", obs); end
    finish_eop;
  endtask

  task automatic test_random;
    logic [7:0] obs, exp, d;
    logic oe, exp_err, rdir;
    int n, m;
    for (int it = 0; it < 10; it++) begin
      do_reset;
      rdir = 1'($urandom_range(0, 1));
      exp_err = 1'b0;
      m = $urandom_range(0, DEPTH + 2);
      if (!rdir) begin
        n = $urandom_range(0, DEPTH + 2);
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          push_tx(d);
          if (txq.size() < DEPTH) txq.push_back(d);
        end
        total++; if (tx_full !== (txq.size() == DEPTH)) begin bad++; $display("FAIL rnd%0d_full got=%0b exp=%0b", it, tx_full, (txq.size() == DEPTH)); end
        arm(1'b0);
        for (int k = 0; k < m; k++) begin
          if (txq.size() > 0) exp = txq.pop_front();
          else begin exp = 8'h00; exp_err = 1'b1; end
          bus_read(obs, oe);
          total++; if (obs !== exp) begin bad++; $display("FAIL rnd%0d_rd%0d got=%0h exp=%0h", it, k, obs, exp); end
          total++; if (bus.dreq !== (txq.size() > 0)) begin bad++; $display("FAIL rnd%0d_rdreq%0d got=%0b exp=%0b", it, k, bus.dreq, (txq.size() > 0)); end
        end
      end else begin
        arm(1'b1);
        for (int k = 0; k < m; k++) begin
          d = 8'($urandom);
          bus_write(d);
          if (rxq.size() < DEPTH) rxq.push_back(d);
          else exp_err = 1'b1;
          total++; if (bus.dreq !== (rxq.size() < DEPTH)) begin bad++; $display("FAIL rnd%0d_wdreq%0d got=%0b exp=%0b", it, k, bus.dreq, (rxq.size() < DEPTH)); end
        end
      end
      total++; if (err !== exp_err) begin bad++; $display("FAIL rnd%0d_err got=%0b exp=%0b", it, err, exp_err); end
      finish_eop;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rnd%0d_done got=%0b exp=1", it, done); end
      while (rxq.size() > 0) begin
        exp = rxq.pop_front();
        total++; if (rx_data !== exp || rx_empty !== 1'b0) begin bad++; $display("FAIL rnd%0d_rx got=%0h/%0b exp=%0h/0", it, rx_data, rx_empty, exp); end
        pop_rx;
      end
      total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rnd%0d_rx_empty got=%0b exp=1", it, rx_empty); end
    end
  endtask

  initial begin
    test_reset;
    test_read_seq;
    test_rx_overflow;
    test_eop;
    test_full_pop_same_cycle;
    test_underflow;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
